// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage of the 8-bit RISC-V pipeline: FSM state,
// data/register widths, and the EX/MEM and MEM/WB bundle layouts.
package mem_stage_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Bundle captured from execute when a memory access is accepted
    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     write_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  reg_write;
    } ex_mem_t;

    // Registered bundle handed to write-back
    typedef struct packed {
        logic                  valid;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     read_data;
    } mem_wb_t;

    // Any data-memory access, read or write
    function automatic logic is_mem_op(input ex_mem_t b);
        return b.mem_read | b.mem_write;
    endfunction

    // A store only when read is not also requested; read takes priority
    function automatic logic is_store(input ex_mem_t b);
        return b.mem_write & ~b.mem_read;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and
// the data memory (slave). The request side stays stable until ready.
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );

endinterface

// File: rtl/mem_access_stage_mem_req_fsm.sv
// Request sequencer for the MEM stage: RUN/ACCESS state, the memory
// request strobe and the upstream stall. With MEM_TIMEOUT_EN defined a
// 4-bit wait counter aborts an access that never sees ready.
module mem_req_fsm
    import mem_stage_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
    parameter int TIMEOUT = 15
)
`endif
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   ready,
    output state_t state,
    output logic   req,
    output logic   stall,
    output logic   done,
    output logic   timeout
);

    // State register: enter ACCESS on a memory op, leave on ready or abort
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (start) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ready || timeout) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign req   = (state == ACCESS);
    assign stall = req & ~ready;
    assign done  = req & ready;

`ifdef MEM_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // Wait counter: held at zero in RUN so every access starts fresh
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (state == RUN) begin
            wait_cnt <= 4'd0;
        end else if (!ready) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Fires on the last tolerated waiting cycle; a ready there wins
    assign timeout = req & ~ready & (wait_cnt == 4'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 8-bit RISC-V pipeline: EX/MEM capture, branch
// resolution, data-memory access over a req/ready bus and the registered
// MEM/WB bundle. Optional macro MEM_TIMEOUT_EN adds an access timeout
// reported on mem_err; without it mem_err is tied low.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int PC_SIZE = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [PC_SIZE-1:0]    PC_jump,
    input  logic                  zero,
    input  logic [DATA_W-1:0]     ALU_result,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  branch_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    output logic                  stall,
    mem_access_stage_if.master    dmem,
    output logic                  pc_src,
    output logic [PC_SIZE-1:0]    PC_branch,
    output logic                  wb_valid,
    output logic                  wb_mem_to_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_alu_result,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic                  mem_err
);

    ex_mem_t bundle_in;
    ex_mem_t q;
    mem_wb_t wb;
    state_t  state;
    logic    accept;
    logic    start;
    logic    req;
    logic    done;
    logic    timeout;

    assign bundle_in = '{
        alu_result: ALU_result,
        write_data: write_data,
        rd:         rd_in,
        mem_read:   mem_read_in,
        mem_write:  mem_write_in,
        mem_to_reg: mem_to_reg_in,
        reg_write:  reg_write_in
    };

    // ex_valid only counts in RUN; in ACCESS the upstream bundle is ignored
    assign accept = (state == RUN) & ex_valid;
    assign start  = accept & is_mem_op(bundle_in);

    mem_req_fsm
`ifdef MEM_TIMEOUT_EN
    #(
        .TIMEOUT (TIMEOUT)
    )
`endif
    u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ready   (dmem.dmem_ready),
        .state   (state),
        .req     (req),
        .stall   (stall),
        .done    (done),
        .timeout (timeout)
    );

    // Request fields come straight from the captured bundle, so they stay
    // stable for the whole access
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & is_store(q);
    assign dmem.dmem_addr  = q.alu_result;
    assign dmem.dmem_wdata = q.write_data;

    // EX/MEM capture of a memory op at acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (start) begin
            q <= bundle_in;
        end
    end

    // Branch resolved at acceptance, including for memory ops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_src    <= 1'b0;
            PC_branch <= '0;
        end else begin
            pc_src <= accept & branch_in & zero;
            if (accept) begin
                PC_branch <= PC_jump;
            end
        end
    end

    // MEM/WB register: direct for ALU ops, on completion/abort for accesses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb <= '0;
        end else if (state == RUN) begin
            if (ex_valid && !is_mem_op(bundle_in)) begin
                wb.valid      <= 1'b1;
                wb.mem_to_reg <= bundle_in.mem_to_reg;
                wb.reg_write  <= bundle_in.reg_write;
                wb.rd         <= bundle_in.rd;
                wb.alu_result <= bundle_in.alu_result;
                wb.read_data  <= '0;
            end else begin
                wb.valid <= 1'b0;
            end
        end else if (done) begin
            wb.valid      <= 1'b1;
            wb.mem_to_reg <= q.mem_to_reg;
            wb.reg_write  <= q.reg_write;
            wb.rd         <= q.rd;
            wb.alu_result <= q.alu_result;
            wb.read_data  <= q.mem_read ? dmem.dmem_rdata : '0;
        end else if (timeout) begin
            // Aborted access retires without a register write
            wb.valid      <= 1'b1;
            wb.mem_to_reg <= q.mem_to_reg;
            wb.reg_write  <= 1'b0;
            wb.rd         <= q.rd;
            wb.alu_result <= q.alu_result;
            wb.read_data  <= '0;
        end else begin
            wb.valid <= 1'b0;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // One-cycle error pulse on an aborted access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

    assign wb_valid      = wb.valid;
    assign wb_mem_to_reg = wb.mem_to_reg;
    assign wb_reg_write  = wb.reg_write;
    assign wb_rd         = wb.rd;
    assign wb_alu_result = wb.alu_result;
    assign wb_read_data  = wb.read_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a transaction-level model of
// the stage plus a data memory drives the DUT and queues expectations;
// independent monitors compare bus, branch and write-back outputs.
module tb_mem_access_stage;

    typedef struct {
        logic       valid;
        logic [9:0] pc;
        logic       zero;
        logic [7:0] alu;
        logic [7:0] wd;
        logic [4:0] rd;
        logic       br, mr, mw, m2r, rw;
    } bundle_t;

    typedef struct {
        int         due;
        logic       err;
        logic       m2r, rw;
        logic [4:0] rd;
        logic [7:0] alu, rdata;
    } wb_exp_t;

    typedef struct {
        logic       src;
        logic [9:0] pc;
    } pc_exp_t;

    typedef struct {
        logic       chk;
        logic       req, stall, bus, we;
        logic [7:0] addr, wdata;
    } cmb_exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid, zero, branch_in, mem_read_in, mem_write_in;
    logic       mem_to_reg_in, reg_write_in;
    logic [9:0] PC_jump;
    logic [7:0] ALU_result, write_data;
    logic [4:0] rd_in;
    logic       stall, pc_src, wb_valid, wb_mem_to_reg, wb_reg_write, mem_err;
    logic [9:0] PC_branch;
    logic [4:0] wb_rd;
    logic [7:0] wb_alu_result, wb_read_data;

    mem_access_stage_if mif ();

    mem_access_stage #(.PC_SIZE(10), .TIMEOUT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .PC_jump       (PC_jump),
        .zero          (zero),
        .ALU_result    (ALU_result),
        .write_data    (write_data),
        .rd_in         (rd_in),
        .branch_in     (branch_in),
        .mem_read_in   (mem_read_in),
        .mem_write_in  (mem_write_in),
        .mem_to_reg_in (mem_to_reg_in),
        .reg_write_in  (reg_write_in),
        .stall         (stall),
        .dmem          (mif),
        .pc_src        (pc_src),
        .PC_branch     (PC_branch),
        .wb_valid      (wb_valid),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    wb_exp_t  wq[$];
    pc_exp_t  pq[$];
    cmb_exp_t cq[$];

    // Reference model state
    logic [7:0] mem_model [256];
    bundle_t    cur;
    bundle_t    qb;
    logic       busy = 1'b0;
    int         wait_left = 0;
    int         force_wait = -1;
    logic       rst_val = 1'b0;
    logic       rst_seen = 1'b0;
    logic [9:0] last_pc = '0;
    logic       consumed;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 15;
    int         acc_cnt = 0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [7:0] alu, input logic [7:0] wd,
                                   input logic [4:0] rd, input logic mr, input logic mw,
                                   input logic m2r, input logic rw, input logic br,
                                   input logic z, input logic [9:0] pc);
        bundle_t b;
        b.valid = 1'b1; b.alu = alu; b.wd = wd; b.rd = rd; b.mr = mr; b.mw = mw;
        b.m2r = m2r; b.rw = rw; b.br = br; b.zero = z; b.pc = pc;
        return b;
    endfunction

    function automatic wb_exp_t mk_wb(input bundle_t b, input logic [7:0] rdata, input int due);
        wb_exp_t e;
        e.due = due; e.err = 1'b0; e.m2r = b.m2r; e.rw = b.rw; e.rd = b.rd;
        e.alu = b.alu; e.rdata = rdata;
        return e;
    endfunction

    // One clock of stimulus plus the reference model's view of that edge
    task automatic tick();
        logic rdy;
        logic acc;
        wb_exp_t e;
        rdy = busy && (wait_left == 0);
        mif.dmem_ready = rdy;
        mif.dmem_rdata = (rdy && qb.mr) ? mem_model[qb.alu] : 8'($urandom);
        rst_n         = rst_val;
        ex_valid      = cur.valid;
        PC_jump       = cur.pc;
        zero          = cur.zero;
        ALU_result    = cur.alu;
        write_data    = cur.wd;
        rd_in         = cur.rd;
        branch_in     = cur.br;
        mem_read_in   = cur.mr;
        mem_write_in  = cur.mw;
        mem_to_reg_in = cur.m2r;
        reg_write_in  = cur.rw;
        cq.push_back('{chk: rst_seen, req: busy, stall: busy && !rdy, bus: rdy,
                       we: qb.mw && !qb.mr, addr: qb.alu, wdata: qb.wd});
        consumed = 1'b0;
        if (!rst_val) begin
            busy = 1'b0;
            last_pc = '0;
            pq.push_back('{src: 1'b0, pc: 10'd0});
            rst_seen = 1'b1;
        end else begin
            acc = cur.valid && !busy;
            if (acc) last_pc = cur.pc;
            pq.push_back('{src: acc && cur.br && cur.zero, pc: last_pc});
            if (busy) begin
                if (rdy) begin
                    wq.push_back(mk_wb(qb, qb.mr ? mem_model[qb.alu] : 8'd0, cyc + 1));
                    if (qb.mw && !qb.mr) mem_model[qb.alu] = qb.wd;
                    busy = 1'b0;
                end else begin
                    wait_left--;
`ifdef MEM_TIMEOUT_EN
                    acc_cnt++;
                    if (acc_cnt == TMO) begin
                        e = mk_wb(qb, 8'd0, cyc + 1);
                        e.err = 1'b1;
                        e.rw = 1'b0;
                        wq.push_back(e);
                        busy = 1'b0;
                    end
`endif
                end
            end else if (acc) begin
                consumed = 1'b1;
                if (cur.mr || cur.mw) begin
                    busy = 1'b1;
                    qb = cur;
                    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
`ifdef MEM_TIMEOUT_EN
                    acc_cnt = 0;
`endif
                end else begin
                    wq.push_back(mk_wb(cur, 8'd0, cyc + 1));
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input bundle_t b);
        cur = b;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (consumed) break;
        end
        if (!consumed) chk("accept_bound", 32'd0, 32'd1);
        cur.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        cur.valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_wb_cleared();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_alu", 32'(wb_alu_result), 32'd0);
        chk("rst_wb_rdata", 32'(wb_read_data), 32'd0);
        chk("rst_wb_ctrl", 32'({wb_mem_to_reg, wb_reg_write}), 32'd0);
        chk("rst_pc_branch", 32'(PC_branch), 32'd0);
    endtask

    // Write-back and branch monitor, sampled just after each rising edge
    initial begin
        wb_exp_t e;
        pc_exp_t p;
        forever begin
            @(posedge clk);
            #1;
            while (wq.size() > 0 && wq[0].due < cyc) begin
                e = wq.pop_front();
                chk("wb_missing", 32'd0, 32'd1);
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
                e = wq.pop_front();
                chk("wb_valid", 32'(wb_valid), 32'd1);
                chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
                chk("wb_read_data", 32'(wb_read_data), 32'(e.rdata));
                chk("mem_err", 32'(mem_err), 32'(e.err));
                if (!e.err) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_alu_result", 32'(wb_alu_result), 32'(e.alu));
                    chk("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e.m2r));
                end
            end else begin
                chk("wb_valid_idle", 32'(wb_valid), 32'd0);
                chk("mem_err_idle", 32'(mem_err), 32'd0);
            end
            if (pq.size() > 0) begin
                p = pq.pop_front();
                chk("pc_src", 32'(pc_src), 32'(p.src));
                chk("PC_branch", 32'(PC_branch), 32'(p.pc));
            end
        end
    end

    // Memory bus and stall monitor, sampled mid-cycle once inputs settle
    initial begin
        cmb_exp_t c;
        #2;
        forever begin
            if (cq.size() > 0) begin
                c = cq.pop_front();
                if (c.chk) begin
                    chk("dmem_req", 32'(mif.dmem_req), 32'(c.req));
                    chk("stall", 32'(stall), 32'(c.stall));
                    if (c.bus) begin
                        chk("dmem_we", 32'(mif.dmem_we), 32'(c.we));
                        chk("dmem_addr", 32'(mif.dmem_addr), 32'(c.addr));
                        chk("dmem_wdata", 32'(mif.dmem_wdata), 32'(c.wdata));
                    end
                end
            end
            @(negedge clk);
            #2;
        end
    end

    initial begin
        bundle_t b;
        int kind;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'($urandom);
        mem_model[8'h10] = 8'hA5;
        cur = mk(8'd0, 8'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
        cur.valid = 1'b0;
        qb = cur;

        rst_val = 1'b0;
        idle(3);
        rst_val = 1'b1;
        check_wb_cleared();

        // ALU op
        send(mk(8'h3C, 8'h00, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h001));
        idle(2);
        // Load with two wait cycles
        force_wait = 2;
        send(mk(8'h10, 8'h00, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h002));
        idle(5);
        // Store with immediate ready, then an ALU op back-to-back
        force_wait = 0;
        send(mk(8'h20, 8'h7E, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h003));
        send(mk(8'h44, 8'h00, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h004));
        // Read back the stored byte
        send(mk(8'h20, 8'h00, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h005));
        idle(3);
        // Branch taken, then not taken
        send(mk(8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h155));
        send(mk(8'h00, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0AA));
        idle(2);
        force_wait = -1;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 2)));
            end else begin
                kind = int'($urandom_range(0, 9));
                b = mk(8'($urandom), 8'($urandom), 5'($urandom), 1'b0, 1'b0,
                       1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom));
                if (kind >= 4) b.alu = 8'($urandom_range(0, 15));
                if (kind >= 4 && kind <= 6) b.mr = 1'b1;
                if (kind == 7 || kind == 8) b.mw = 1'b1;
                if (kind == 9) begin b.mr = 1'b1; b.mw = 1'b1; end
                send(b);
            end
        end
        idle(5);

        // Reset arriving in the middle of an access
        force_wait = 1000;
        send(mk(8'h08, 8'h00, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h1F0));
        idle(3);
        rst_val = 1'b0;
        idle(1);
        rst_val = 1'b1;
        check_wb_cleared();
        force_wait = -1;
        idle(3);
        send(mk(8'h5A, 8'h00, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h010));
        idle(2);

`ifdef MEM_TIMEOUT_EN
        // Load that never completes
        force_wait = 1000;
        send(mk(8'h0C, 8'h00, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h020));
        idle(20);
        force_wait = -1;
        send(mk(8'h11, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h021));
        idle(3);
`endif

        idle(4);
        @(posedge clk);
        #2;
        chk("wb_queue_drained", 32'(wq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
